// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: UART transmitter for the debug unit's byte stream.
// A frame is sent LSB-first as one start bit, DBIT data bits, an optional
// even-parity bit and one stop bit. os_tx_done pulses for one cycle when the
// frame ends.
// Optional feature: define UART_TX_PARITY_EN to add the even-parity bit.
module uart_tx_serializer #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD_RATE  = 19200,
  parameter int unsigned DBIT       = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_tx_data,
  input  logic       is_tx_start,
  output logic       o_tx,
  output logic       os_tx_done,
  output logic       o_tx_busy
);

  localparam int unsigned DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned TICK_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned OS_W    = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned BIT_W   = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd4,
`endif
    S_STOP   = 3'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [TICK_W-1:0] r_tick_cnt;
  logic [TICK_W-1:0] w_tick_cnt_next;
  logic [OS_W-1:0]   r_os_cnt;
  logic [OS_W-1:0]   w_os_cnt_next;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic [BIT_W-1:0]  w_bit_cnt_next;
  logic [DBIT-1:0]   r_shift;
  logic [DBIT-1:0]   w_shift_next;
  logic              r_tx;
  logic              r_done;
  logic              r_busy;
  logic              w_tx_next;
  logic              w_done_next;
  logic              w_busy_next;
  logic              w_tick;
  logic              w_os_last;
  logic              w_bit_end;
`ifdef UART_TX_PARITY_EN
  logic              r_parity;
`endif

  assign w_tick    = (r_tick_cnt == TICK_W'(DIV - 1));
  assign w_os_last = (r_os_cnt == OS_W'(OVERSAMPLE - 1));
  assign w_bit_end = w_tick && w_os_last;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  // Next-state and datapath next values; counters run only outside IDLE
  always_comb begin
    w_state_next    = r_state;
    w_tick_cnt_next = w_tick ? '0 : r_tick_cnt + TICK_W'(1);
    w_os_cnt_next   = r_os_cnt;
    w_bit_cnt_next  = r_bit_cnt;
    w_shift_next    = r_shift;
    if (w_tick) w_os_cnt_next = w_os_last ? '0 : r_os_cnt + OS_W'(1);
    case (r_state)
      S_IDLE: begin
        w_tick_cnt_next = '0;
        w_os_cnt_next   = '0;
        w_bit_cnt_next  = '0;
        if (is_tx_start) begin
          w_shift_next = i_tx_data[DBIT-1:0];
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) w_state_next = S_DATA;
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_shift_next = r_shift >> 1;
          if (r_bit_cnt == BIT_W'(DBIT - 1)) begin
            w_bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
            w_state_next   = S_PARITY;
`else
            w_state_next   = S_STOP;
`endif
          end else begin
            w_bit_cnt_next = r_bit_cnt + BIT_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) w_state_next = S_STOP;
      end
`endif
      S_STOP: begin
        if (w_bit_end) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the pins are registered
  always_comb begin
    w_tx_next   = 1'b1;
    w_done_next = (r_state == S_STOP) && w_bit_end;
    w_busy_next = (w_state_next != S_IDLE);
    case (w_state_next)
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_tx_next = r_parity;
`endif
      default:  w_tx_next = 1'b1;
    endcase
  end

  // Counters and shift register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tick_cnt <= '0;
      r_os_cnt   <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
    end else begin
      r_tick_cnt <= w_tick_cnt_next;
      r_os_cnt   <= w_os_cnt_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_shift    <= w_shift_next;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Even parity of the accepted byte, captured with the data
  always_ff @(posedge clk) begin
    if (!rst)                                 r_parity <= 1'b0;
    else if (r_state == S_IDLE && is_tx_start) r_parity <= ^i_tx_data[DBIT-1:0];
  end
`endif

  // Registered line, done pulse and busy flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tx   <= 1'b1;
      r_done <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_tx   <= w_tx_next;
      r_done <= w_done_next;
      r_busy <= w_busy_next;
    end
  end

  assign o_tx       = r_tx;
  assign os_tx_done = r_done;
  assign o_tx_busy  = r_busy;

endmodule
